// File: rtl/alu_driver.sv
// alu_driver: on-board stimulus master and checker for the 6-bit nvboard ALU.
// Drives sw = {op, a, b}, holds it for SETTLE cycles, then compares the returned
// LED word against a built-in golden model. Error count, first failing vector and
// pass/done flags are left on the outputs for the board to display.
// Optional feature: define LFSR_EN to take operands from a 12-bit Fibonacci LFSR
// (x^12+x^6+x^4+x+1, seeded with LFSR_SEED). Without it, a 12-bit counter stepping
// by 67 supplies the operands.
//
// state | meaning
// IDLE  | waiting for start after reset
// DRIVE | sw held for SETTLE cycles so the ALU output settles
// CHECK | ledr_in compared against the golden model; vector advances on this edge
// DONE  | run finished; results held until the next start
module alu_driver #(
  parameter int          VEC_PER_OP = 64,
  parameter int          SETTLE     = 2,
  parameter logic [11:0] LFSR_SEED  = 12'hACE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [14:0] ledr_in,
  output logic [14:0] sw,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_cnt,
  output logic [14:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam logic [7:0] VEC_LAST  = 8'(VEC_PER_OP - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

`ifdef LFSR_EN
  localparam logic [11:0] OPND_INIT = LFSR_SEED;
`else
  // The seed only matters for the LFSR build; it is folded away here.
  localparam logic [11:0] OPND_INIT = 12'd0 & LFSR_SEED;
`endif

  state_t      state, state_nx;
  logic [3:0]  settle_cnt;
  logic [7:0]  vec_cnt;
  logic        accept;
  logic        advance;
  logic        last_vec;
  logic        mismatch;
  logic [14:0] expected;
  logic [11:0] opnd_nx;
  logic [2:0]  op_nx;

  // Golden model of the ALU; bits 14:9 are always zero.
  function automatic logic [14:0] golden(input logic [2:0] op,
                                         input logic [5:0] a,
                                         input logic [5:0] b);
    logic [6:0] s;
    logic [5:0] nb;
    logic [5:0] d;
    logic [8:0] r;
    r  = '0;
    s  = '0;
    nb = ~b + 6'd1;
    d  = a - b;
    case (op)
      3'd0: begin
        s      = {1'b0, a} + {1'b0, b};
        r[6:0] = s;
        r[7]   = ~|r[6:0];
        r[8]   = r[6] ^ r[5];
      end
      3'd1: begin
        s      = {1'b0, a} + {1'b0, nb};
        r[5:0] = s[5:0];
        r[6]   = ~s[6];
        r[7]   = ~|r[6:0];
        r[8]   = r[6] ^ r[5];
      end
      3'd2: r[5:0] = ~a;
      3'd3: r[5:0] = a & b;
      3'd4: r[5:0] = a | b;
      3'd5: r[5:0] = a ^ b;
      3'd6: r[0]   = d[5];
      default: r[0] = (a == b);
    endcase
    return {6'd0, r};
  endfunction

  assign expected = golden(sw[14:12], sw[11:6], sw[5:0]);
  assign mismatch = (ledr_in != expected);
  assign last_vec = (sw[14:12] == 3'd7) && (vec_cnt == VEC_LAST);
  assign op_nx    = (vec_cnt == VEC_LAST) ? sw[14:12] + 3'd1 : sw[14:12];

`ifdef LFSR_EN
  assign opnd_nx = {sw[10:0], sw[11] ^ sw[5] ^ sw[3] ^ sw[0]};
`else
  assign opnd_nx = sw[11:0] + 12'd67;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    advance  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt == 4'd0) state_nx = CHECK;
      end
      CHECK: begin
        advance  = 1'b1;
        state_nx = last_vec ? DONE : DRIVE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stimulus, settle timer and result bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw         <= '0;
      settle_cnt <= '0;
      vec_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
    end else if (accept) begin
      sw         <= {3'd0, OPND_INIT};
      settle_cnt <= SETTLE_LD;
      vec_cnt    <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
    end else begin
      if (state == DRIVE && settle_cnt != 4'd0)
        settle_cnt <= settle_cnt - 4'd1;
      if (advance) begin
        if (mismatch) begin
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          if (err_cnt == 8'd0)  fail_vec <= sw;
        end
        if (last_vec) begin
          // sw is left on the final vector so the board shows where the run ended.
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_cnt == 8'd0) && !mismatch;
        end else begin
          sw         <= {op_nx, opnd_nx};
          vec_cnt    <= (vec_cnt == VEC_LAST) ? 8'd0 : vec_cnt + 8'd1;
          settle_cnt <= SETTLE_LD;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: randomized runs of alu_driver against a behavioural ALU attached
// to sw/ledr_in (clean, randomly corrupted, bit 7 stuck low, tied high), with a
// scoreboard of expected vectors and end-of-run results built from a reference model.
module tb_alu_driver;

  localparam int          V      = 40;
  localparam int          S      = 2;
  localparam logic [11:0] SEED   = 12'hACE;
  localparam int          PERIOD = S + 1;
  localparam int          NVEC   = 8 * V;

  typedef struct {
    int err;
    int pass;
    int fvec;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [14:0] ledr_in;
  logic [14:0] sw;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_cnt;
  logic [14:0] fail_vec;

  int          fault_mode = 0;
  logic [3:0]  fault_nib  = 4'd0;
  logic [14:0] fault_mask = 15'd0;

  int checks   = 0;
  int failures = 0;

  logic [14:0] exp_sw[$];
  res_t        exp_res[$];

  alu_driver #(.VEC_PER_OP(V), .SETTLE(S), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ledr_in(ledr_in),
    .sw(sw), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  // Reference ALU written with plain integer arithmetic.
  function automatic int alu_ref(int op, int a, int b);
    int s;
    int r;
    r = 0;
    case (op)
      0: begin
        s = a + b;
        r = s;
        if (s == 0) r += 128;
        if ((((s >> 6) ^ (s >> 5)) & 1) == 1) r += 256;
      end
      1: begin
        s = a + ((64 - b) % 64);
        r = s % 64;
        if (s < 64) r += 64;
        if ((r % 128) == 0) r += 128;
        if ((((r >> 6) ^ (r >> 5)) & 1) == 1) r += 256;
      end
      2: r = 63 - a;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (((a - b + 64) % 64) >= 32) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
    return r;
  endfunction

  // Behaviour of the ALU on the board, including injected faults.
  function automatic logic [14:0] alu_board(int mode, logic [14:0] v,
                                            logic [3:0] nib, logic [14:0] mask);
    logic [14:0] g;
    g = 15'(alu_ref(int'(v[14:12]), int'(v[11:6]), int'(v[5:0])));
    case (mode)
      1:       return (v[3:0] == nib) ? (g ^ mask) : g;
      2:       return 15'h7FFF;
      3:       return g & ~15'h0080;
      default: return g;
    endcase
  endfunction

  assign ledr_in = alu_board(fault_mode, sw, fault_nib, fault_mask);

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Build the expected vector list and end-of-run result for the current fault mode.
  task automatic plan_run();
    logic [11:0] opnd;
    logic [14:0] v;
    int          nerr;
    int          first;
    res_t        r;
`ifdef LFSR_EN
    opnd = SEED;
`else
    opnd = 12'd0;
`endif
    nerr  = 0;
    first = 0;
    for (int k = 0; k < NVEC; k++) begin
      v = {3'(k / V), opnd};
      exp_sw.push_back(v);
      if (int'(alu_board(fault_mode, v, fault_nib, fault_mask)) !=
          alu_ref(k / V, int'(opnd[11:6]), int'(opnd[5:0]))) begin
        if (nerr == 0) first = int'(v);
        nerr++;
      end
`ifdef LFSR_EN
      opnd = {opnd[10:0], opnd[11] ^ opnd[5] ^ opnd[3] ^ opnd[0]};
`else
      opnd = 12'((int'(opnd) + 67) % 4096);
`endif
    end
    r.err  = (nerr > 255) ? 255 : nerr;
    r.pass = (nerr == 0) ? 1 : 0;
    r.fvec = first;
    exp_res.push_back(r);
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_sw"}, int'(sw), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    chk({tag, "_fail_vec"}, int'(fail_vec), 0);
  endtask

  // One run: optional ignored start mid-run, optional reset mid-run (aborts the run).
  task automatic run(int mode, int inj_start_at, int inj_rst_at);
    int budget;
    fault_mode = mode;
    fault_nib  = 4'($urandom_range(0, 15));
    fault_mask = 15'($urandom_range(1, 32767));
    plan_run();
    repeat ($urandom_range(1, 5)) @(negedge clk);
    #2 start = 1'b1;
    @(negedge clk);
    #2 start = 1'b0;
    budget = NVEC * PERIOD + 20;
    for (int c = 1; c < budget; c++) begin
      @(negedge clk);
      #2;
      if (done) break;
      start = (c == inj_start_at);
      if (c == inj_rst_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1 check_reset_state("midrun_rst");
        exp_sw.delete();
        exp_res.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        return;
      end
    end
    start = 1'b0;
    chk("done_reached", int'(done), 1);
    @(negedge clk);
  endtask

  // Monitor: compares each presented vector and the end-of-run result.
  int cyc = 0;
  logic busy_p = 1'b0;
  logic done_p = 1'b0;
  initial begin
    logic [14:0] e;
    res_t        r;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        busy_p = 1'b0;
        done_p = 1'b0;
      end else begin
        if (busy && !busy_p) cyc = 0;
        else                 cyc++;
        if (busy && (cyc % PERIOD) == 0) begin
          if (exp_sw.size() == 0) chk("sw_unexpected", int'(sw), -1);
          else begin
            e = exp_sw.pop_front();
            chk("sw", int'(sw), int'(e));
          end
        end
        if (done && !done_p) begin
          chk("done_edge", cyc, NVEC * PERIOD);
          chk("vectors_left", exp_sw.size(), 0);
          if (exp_res.size() == 0) chk("res_unexpected", int'(done), -1);
          else begin
            r = exp_res.pop_front();
            chk("err_cnt", int'(err_cnt), r.err);
            chk("pass", int'(pass), r.pass);
            chk("fail_vec", int'(fail_vec), r.fvec);
            chk("busy_at_done", int'(busy), 0);
          end
        end
        busy_p = busy;
        done_p = done;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    #2 rst_n = 1'b1;
    run(0, $urandom_range(10, 500), -1);
    run(1, -1, -1);
    run(3, -1, -1);
    run(2, $urandom_range(10, 500), -1);
    run(0, -1, 100);
    run(0, -1, -1);
    run(1, $urandom_range(10, 500), -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
